// File: rtl/gcd_pkg.sv
// Shared types and default widths for the subtractive-Euclid GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_W  = 16;
  localparam int unsigned GCD_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result valid-ready bundle between producer, GCD engine and consumer.
interface gcd_engine_if #(
  parameter int unsigned W  = gcd_pkg::GCD_W,
  parameter int unsigned CW = gcd_pkg::GCD_CW
);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [CW-1:0] iter_count;
  logic          err;

  // Producer/consumer side.
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, iter_count, err
  );

  // Engine side.
  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, result, iter_count, err
  );

endinterface

// File: rtl/gcd_datapath.sv
// A/B operand registers, a single shared subtractor and the compare flags.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned W = GCD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_zero,
  output logic         b_zero
);

  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic [W-1:0] diff;

  assign a_gt_b = a > b;
  assign a_eq_b = a == b;
  assign a_zero = a == '0;
  assign b_zero = b == '0;

  // Larger minus smaller, so the difference never wraps.
  assign minuend    = a_gt_b ? a : b;
  assign subtrahend = a_gt_b ? b : a;
  assign diff       = minuend - subtrahend;

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else if (load) begin
      a <= a_in;
      b <= b_in;
    end else if (step) begin
      if (a_gt_b) a <= diff;
      else        b <= diff;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Self-sequencing GCD engine: control FSM, saturating step counter, result registers.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned W  = GCD_W,
  parameter int unsigned CW = GCD_CW
) (
  input logic        clk,
  input logic        reset,
  gcd_engine_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  result_q;
  logic [CW-1:0] iter_count_q;
  logic          err_q;

  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          a_gt_b;
  logic          a_eq_b;
  logic          a_zero;
  logic          b_zero;
  logic          accept;
  logic          terminal;
  logic          step;

  assign accept   = bus.in_valid && in_ready_q;
  assign terminal = a_zero || b_zero || a_eq_b;
  assign step     = (state == RUN) && !terminal;

  gcd_datapath #(.W(W)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (step),
    .a_in   (bus.a_in),
    .b_in   (bus.b_in),
    .a      (a),
    .b      (b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_zero (a_zero),
    .b_zero (b_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      iter_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (terminal) begin
            // A|B covers both the one-zero case and A==B.
            result_q     <= a | b;
            err_q        <= a_zero && b_zero;
            iter_count_q <= cnt;
            state        <= DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by reset so no operand is taken while reset is asserted.
  assign bus.in_ready   = in_ready_q && !reset;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.iter_count = iter_count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed cases, backpressure, reset, saturation, random pairs.
module tb_gcd_engine;
  import gcd_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_engine_if #(.W(16), .CW(16)) bus ();
  gcd_engine_if #(.W(16), .CW(8))  sbus ();

  gcd_engine #(.W(16), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  gcd_engine #(.W(16), .CW(8)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Euclid by division; each quotient q contributes q subtractions (q-1 on the final exact one).
  function automatic void ref_gcd(input int a_i, input int b_i,
                                  output int g, output int k, output bit e);
    int a = a_i;
    int b = b_i;
    k = 0;
    e = (a == 0) && (b == 0);
    if (a == 0 || b == 0) begin
      g = a + b;
      return;
    end
    while (a != b) begin
      if (a > b) begin
        if (a % b == 0) begin k += a / b - 1; a = b; end
        else begin k += a / b; a = a % b; end
      end else begin
        if (b % a == 0) begin k += b / a - 1; b = a; end
        else begin k += b / a; b = b % a; end
      end
    end
    g = a;
  endfunction

  // One operation on the CW=16 engine; stall>0 holds out_ready low for that many cycles of out_valid.
  task automatic run_op(input int a, input int b, input int stall);
    int g, k, lat;
    bit e, got;
    ref_gcd(a, b, g, k, e);
    @(negedge clk);
    bus.a_in      = 16'(a);
    bus.b_in      = 16'(b);
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 32'(got), 32'd1);
    if (!got) begin bus.in_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a_in     = 16'($urandom);
    bus.b_in     = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= k + 50; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin lat = n; break; end
    end
    chk("latency", 32'(lat), 32'(k + 2));
    chk("result", 32'(bus.result), 32'(g));
    chk("iter_count", 32'(bus.iter_count), 32'(k));
    chk("err", 32'(bus.err), 32'(e));
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = 1'b1;
        bus.a_in     = 16'd100;
        bus.b_in     = 16'd75;
        @(posedge clk);
        #1;
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_result", 32'(bus.result), 32'(g));
        chk("hold_iter", 32'(bus.iter_count), 32'(k));
        chk("hold_err", 32'(bus.err), 32'(e));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int g, k, lat;
    bit e;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.out_ready  = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.a_in      = '0;
    sbus.b_in      = '0;
    sbus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_iter", 32'(bus.iter_count), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases
    run_op(12, 18, 0);
    run_op(48, 18, 0);
    run_op(7, 7, 0);
    run_op(0, 9, 0);
    run_op(9, 0, 0);
    run_op(0, 0, 0);
    run_op(12, 18, 5);

    // Reset on the second RUN cycle of (48,18)
    @(negedge clk);
    bus.a_in     = 16'd48;
    bus.b_in     = 16'd18;
    bus.in_valid = 1'b1;
    chk("mid_accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_iter", 32'(bus.iter_count), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(12, 18, 0);

    // Random pairs with occasional zeros and backpressure
    for (int i = 0; i < 30; i++) begin
      int ra = $urandom_range(0, 255);
      int rb = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) ra = 0;
      if ($urandom_range(0, 9) == 0) rb = 0;
      run_op(ra, rb, $urandom_range(0, 2));
    end

    // Counter saturation on the CW=8 instance
    ref_gcd(65535, 1, g, k, e);
    @(negedge clk);
    sbus.a_in     = 16'hFFFF;
    sbus.b_in     = 16'd1;
    sbus.in_valid = 1'b1;
    chk("sat_in_ready", 32'(sbus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk);
      #1;
      if (sbus.out_valid) begin lat = n; break; end
    end
    chk("sat_latency", 32'(lat), 32'(k + 2));
    chk("sat_result", 32'(sbus.result), 32'(g));
    chk("sat_iter", 32'(sbus.iter_count), 32'd255);
    chk("sat_err", 32'(sbus.err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
